// File: rtl/riscv_alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// riscv_alu_arb_pkg : shared types and ALU control constants for the arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
`ifndef RV32I_DEFINES_SV
`include "rv32i_defines.sv"
`endif
`default_nettype none

package riscv_alu_arb_pkg;

  localparam int RV_XLEN    = `XLEN;
  localparam int ALU_CTRL_W = 5;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = `ALU_CTRL_ADD;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = `ALU_CTRL_SUB;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = `ALU_CTRL_SLL;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = `ALU_CTRL_SLT;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = `ALU_CTRL_SLTU;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = `ALU_CTRL_XOR;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = `ALU_CTRL_SRL;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = `ALU_CTRL_SRA;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = `ALU_CTRL_OR;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = `ALU_CTRL_AND;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

`default_nettype wire

// File: rtl/riscv_alu.sv
// -----------------------------------------------------------------------------
// riscv_alu : combinational RV32I integer ALU with zero flag
// Rev 1.0
// -----------------------------------------------------------------------------
`ifndef RV32I_DEFINES_SV
`include "rv32i_defines.sv"
`endif
`default_nettype none

module riscv_alu
  import riscv_alu_arb_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic [XLEN-1:0]       a_i,
  input  logic [XLEN-1:0]       b_i,
  input  logic [ALU_CTRL_W-1:0] ctrl_i,
  output logic [XLEN-1:0]       result_o,
  output logic                  zero_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt_w;
  assign shamt_w = b_i[SHW-1:0];

  // Unlisted control codes produce zero; the arbiter forwards whatever appears here.
  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt_w;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt_w;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt_w;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

`default_nettype wire

// File: rtl/rv32i_defines.sv
// Shared RV32I defines: datapath width and ALU control encodings.
`ifndef RV32I_DEFINES_SV
`define RV32I_DEFINES_SV

`define XLEN 32

`define ALU_CTRL_ADD  5'd0
`define ALU_CTRL_SUB  5'd1
`define ALU_CTRL_SLL  5'd2
`define ALU_CTRL_SLT  5'd3
`define ALU_CTRL_SLTU 5'd4
`define ALU_CTRL_XOR  5'd5
`define ALU_CTRL_SRL  5'd6
`define ALU_CTRL_SRA  5'd7
`define ALU_CTRL_OR   5'd8
`define ALU_CTRL_AND  5'd9

`endif

// File: rtl/riscv_alu_arb.sv
// -----------------------------------------------------------------------------
// riscv_alu_arb : two-requester arbiter sharing one ALU, registered response
// Rev 1.0
// -----------------------------------------------------------------------------
`ifndef RV32I_DEFINES_SV
`include "rv32i_defines.sv"
`endif
`default_nettype none

module riscv_alu_arb
  import riscv_alu_arb_pkg::*;
#(
  parameter int P_RR = 1,
  parameter int XLEN = `XLEN
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [XLEN-1:0]       i_req0_a,
  input  logic [XLEN-1:0]       i_req0_b,
  input  logic [ALU_CTRL_W-1:0] i_req0_ctrl,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [XLEN-1:0]       i_req1_a,
  input  logic [XLEN-1:0]       i_req1_b,
  input  logic [ALU_CTRL_W-1:0] i_req1_ctrl,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_id,
  output logic [XLEN-1:0]       o_rsp_result,
  output logic                  o_rsp_zero
);

  localparam logic RR_EN = (P_RR != 0);

  rsp_state_e             state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic                   id_q, id_d;
  logic [XLEN-1:0]        result_q, result_d;
  logic                   zero_q, zero_d;

  logic                   gnt0_w, gnt1_w, accept_w, hs_w;
  logic [XLEN-1:0]        alu_a_w, alu_b_w, alu_res_w;
  logic [ALU_CTRL_W-1:0]  alu_ctrl_w;
  logic                   alu_zero_w;

  // Requester 1 wins when alone, or on a tie when round-robin points at it.
  assign gnt1_w   = i_req1_valid & (~i_req0_valid | (RR_EN & ptr_q));
  assign gnt0_w   = i_req0_valid & ~gnt1_w;
  assign accept_w = (state_q == RSP_EMPTY) | i_rsp_ready;

  assign o_req0_ready = accept_w & gnt0_w;
  assign o_req1_ready = accept_w & gnt1_w;
  assign hs_w         = o_req0_ready | o_req1_ready;

  assign alu_a_w    = gnt1_w ? i_req1_a    : i_req0_a;
  assign alu_b_w    = gnt1_w ? i_req1_b    : i_req0_b;
  assign alu_ctrl_w = gnt1_w ? i_req1_ctrl : i_req0_ctrl;

  riscv_alu #(
    .XLEN     (XLEN)
  ) u_alu (
    .a_i      (alu_a_w),
    .b_i      (alu_b_w),
    .ctrl_i   (alu_ctrl_w),
    .result_o (alu_res_w),
    .zero_o   (alu_zero_w)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (hs_w) begin
      state_d  = RSP_FULL;
      ptr_d    = ~gnt1_w;
      id_d     = gnt1_w;
      result_d = alu_res_w;
      zero_d   = alu_zero_w;
    end else if (i_rsp_ready) begin
      state_d  = RSP_EMPTY;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= RSP_EMPTY;
      ptr_q    <= 1'b0;
      id_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign o_rsp_valid  = (state_q == RSP_FULL);
  assign o_rsp_id     = id_q;
  assign o_rsp_result = result_q;
  assign o_rsp_zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_alu_arb.sv
// Directed and randomised checks of riscv_alu_arb (round-robin and fixed-priority instances).
`default_nettype none

module tb_riscv_alu_arb;
  import riscv_alu_arb_pkg::*;

  localparam int W = RV_XLEN;

  typedef struct {
    logic       port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0] ctrl;
    logic [W-1:0] res;
    logic       zero;
  } vec_t;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
  } exp_t;

  logic         clk;
  logic         rstn;
  logic         v0, v1, rsp_ready;
  logic [W-1:0] a0, b0, a1, b1;
  logic [4:0]   c0, c1;

  logic         r0, r1, rsp_valid, rsp_id, rsp_zero;
  logic [W-1:0] rsp_result;
  logic         fr0, fr1, f_valid, f_id, f_zero;
  logic [W-1:0] f_result;

  int checks   = 0;
  int failures = 0;

  riscv_alu_arb #(.P_RR(1)) u_dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_ctrl(c0),
    .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_ctrl(c1),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero)
  );

  riscv_alu_arb #(.P_RR(0)) u_dut_fixed (
    .i_clk(clk), .i_rstn(rstn),
    .i_req0_valid(v0), .o_req0_ready(fr0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_ctrl(c0),
    .i_req1_valid(v1), .o_req1_ready(fr1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_ctrl(c1),
    .o_rsp_valid(f_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(f_id),
    .o_rsp_result(f_result), .o_rsp_zero(f_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  function automatic logic [W-1:0] ref_op(input logic [4:0] c, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    if (c == ALU_SLT)       r = ($signed(a) < $signed(b)) ? 1 : 0;
    else if (c == ALU_SLTU) r = (a < b) ? 1 : 0;
    else if (c == ALU_SRA)  r = $signed(a) >>> b[4:0];
    return r;
  endfunction

  task automatic gen(output logic [W-1:0] a, output logic [W-1:0] b, output logic [4:0] c);
    case ($urandom_range(2))
      0:       c = ALU_SLT;
      1:       c = ALU_SLTU;
      default: c = ALU_SRA;
    endcase
    a = $urandom;
    b = ($urandom_range(3) == 0) ? W'($urandom_range(31)) : W'($urandom);
    if ($urandom_range(7) == 0) b = a;
  endtask

  vec_t vecs[14];
  exp_t exp_q[$];

  initial begin
    exp_t e;
    logic hs0, hs1;
    int   accepted, returned;

    vecs[0]  = '{1'b0, 32'd5,          32'd7,        ALU_ADD,  32'd12,         1'b0};
    vecs[1]  = '{1'b1, 32'd3,          32'd5,        ALU_SUB,  32'hFFFF_FFFE,  1'b0};
    vecs[2]  = '{1'b0, 32'd9,          32'd9,        ALU_SUB,  32'd0,          1'b1};
    vecs[3]  = '{1'b1, 32'd1,          32'd4,        ALU_SLL,  32'd16,         1'b0};
    vecs[4]  = '{1'b0, 32'h8000_0000,  32'd31,       ALU_SRL,  32'd1,          1'b0};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'd4,        ALU_SRA,  32'hF800_0000,  1'b0};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,        ALU_SLT,  32'd1,          1'b0};
    vecs[7]  = '{1'b1, 32'hFFFF_FFFF,  32'd1,        ALU_SLTU, 32'd0,          1'b1};
    vecs[8]  = '{1'b0, 32'h0000_00F0,  32'h0000_000F, ALU_XOR, 32'h0000_00FF,  1'b0};
    vecs[9]  = '{1'b1, 32'h0000_F0F0,  32'h0000_0F00, ALU_OR,  32'h0000_FFF0,  1'b0};
    vecs[10] = '{1'b0, 32'h0000_F0F0,  32'h0000_0FF0, ALU_AND, 32'h0000_00F0,  1'b0};
    vecs[11] = '{1'b1, 32'hFFFF_FFFF,  32'd1,        ALU_ADD,  32'd0,          1'b1};
    vecs[12] = '{1'b0, 32'd1,          32'd33,       ALU_SLL,  32'd2,          1'b0};
    vecs[13] = '{1'b1, 32'd7,          32'd7,        5'd31,    32'd0,          1'b1};

    rstn = 1'b0; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
    a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0;
    #2;
    check("reset_valid",  rsp_valid,  0);
    check("reset_id",     rsp_id,     0);
    check("reset_result", rsp_result, 0);
    check("reset_zero",   rsp_zero,   0);
    step();
    rstn = 1'b1;

    // Single-requester vectors, back to back with the consumer always ready.
    for (int i = 0; i < 14; i++) begin
      v0 = (vecs[i].port == 1'b0);
      v1 = (vecs[i].port == 1'b1);
      a0 = vecs[i].a; b0 = vecs[i].b; c0 = vecs[i].ctrl;
      a1 = vecs[i].a; b1 = vecs[i].b; c1 = vecs[i].ctrl;
      #1;
      check($sformatf("vec%0d_ready0", i), r0, v0);
      check($sformatf("vec%0d_ready1", i), r1, v1);
      step();
      check($sformatf("vec%0d_valid", i),  rsp_valid,  1);
      check($sformatf("vec%0d_id", i),     rsp_id,     vecs[i].port);
      check($sformatf("vec%0d_result", i), rsp_result, vecs[i].res);
      check($sformatf("vec%0d_zero", i),   rsp_zero,   vecs[i].zero);
    end
    v0 = 1'b0; v1 = 1'b0;

    // Tie from reset: requester 0 first, then requester 1.
    do_reset();
    v0 = 1'b1; a0 = 32'd9;    b0 = 32'd9;    c0 = ALU_SUB;
    v1 = 1'b1; a1 = 32'hF0;   b1 = 32'h0F;   c1 = ALU_XOR;
    rsp_ready = 1'b1;
    #1;
    check("tie_ready0", r0, 1);
    check("tie_ready1", r1, 0);
    step();
    check("tie_first_id",     rsp_id,     0);
    check("tie_first_result", rsp_result, 0);
    check("tie_first_zero",   rsp_zero,   1);
    v0 = 1'b0;
    #1;
    check("tie_second_ready1", r1, 1);
    step();
    check("tie_second_id",     rsp_id,     1);
    check("tie_second_result", rsp_result, 32'hFF);
    check("tie_second_zero",   rsp_zero,   0);
    v1 = 1'b0;

    // Continuous contention: round-robin alternates, fixed priority sticks to 0.
    do_reset();
    v0 = 1'b1; a0 = 32'd1; b0 = 32'd2; c0 = ALU_ADD;
    v1 = 1'b1; a1 = 32'd3; b1 = 32'd4; c1 = ALU_ADD;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("fix%0d_ready0", i), fr0, 1);
      check($sformatf("fix%0d_ready1", i), fr1, 0);
      step();
      check($sformatf("rr%0d_id", i),      rsp_id,     W'(i % 2));
      check($sformatf("rr%0d_result", i),  rsp_result, (i % 2 == 0) ? 32'd3 : 32'd7);
      check($sformatf("fix%0d_valid", i),  f_valid,    1);
      check($sformatf("fix%0d_id", i),     f_id,       0);
      check($sformatf("fix%0d_result", i), f_result,   32'd3);
      check($sformatf("fix%0d_zero", i),   f_zero,     0);
    end
    v0 = 1'b0;
    step();
    check("fix_after_drop_id",     f_id,     1);
    check("fix_after_drop_result", f_result, 32'd7);
    v1 = 1'b0;

    // Backpressure: held response stays stable, then drain and refill in one cycle.
    do_reset();
    v0 = 1'b1; a0 = 32'd1; b0 = 32'd4; c0 = ALU_SLL;
    rsp_ready = 1'b1;
    step();
    v0 = 1'b0;
    v1 = 1'b1; a1 = 32'd2; b1 = 32'd3; c1 = ALU_ADD;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_ready0", i), r0,         0);
      check($sformatf("bp%0d_ready1", i), r1,         0);
      check($sformatf("bp%0d_valid", i),  rsp_valid,  1);
      check($sformatf("bp%0d_id", i),     rsp_id,     0);
      check($sformatf("bp%0d_result", i), rsp_result, 32'd16);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_refill_ready1", r1, 1);
    step();
    check("bp_refill_valid",  rsp_valid,  1);
    check("bp_refill_id",     rsp_id,     1);
    check("bp_refill_result", rsp_result, 32'd5);
    v1 = 1'b0;
    step();
    check("bp_drain_valid", rsp_valid, 0);

    // Asynchronous reset while full; pointer must return to requester 0.
    v0 = 1'b1; a0 = 32'd1; b0 = 32'd1; c0 = ALU_ADD;
    step();
    check("ar_full_valid", rsp_valid, 1);
    v0 = 1'b0;
    rsp_ready = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("ar_valid",  rsp_valid,  0);
    check("ar_result", rsp_result, 0);
    check("ar_zero",   rsp_zero,   0);
    step();
    rstn = 1'b1;
    v0 = 1'b1; a0 = 32'd1; b0 = 32'd2; c0 = ALU_ADD;
    v1 = 1'b1; a1 = 32'd3; b1 = 32'd4; c1 = ALU_ADD;
    rsp_ready = 1'b1;
    #1;
    check("ar_ptr_ready0", r0, 1);
    check("ar_ptr_ready1", r1, 0);
    step();
    check("ar_ptr_id",     rsp_id,     0);
    check("ar_ptr_result", rsp_result, 32'd3);
    v0 = 1'b0; v1 = 1'b0;

    // Randomised SLT/SLTU/SRA traffic against an in-order scoreboard.
    do_reset();
    accepted = 0;
    returned = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!v0 && $urandom_range(3) != 0) begin v0 = 1'b1; gen(a0, b0, c0); end
      if (!v1 && $urandom_range(3) != 0) begin v1 = 1'b1; gen(a1, b1, c1); end
      rsp_ready = ($urandom_range(3) != 0);
      #1;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          returned++;
          check("rnd_id",     rsp_id,     e.id);
          check("rnd_result", rsp_result, e.res);
          check("rnd_zero",   rsp_zero,   (e.res == '0));
        end
      end
      check("rnd_one_ready", r0 & r1, 0);
      hs0 = r0;
      hs1 = r1;
      if (hs0) begin exp_q.push_back('{1'b0, ref_op(c0, a0, b0)}); accepted++; end
      if (hs1) begin exp_q.push_back('{1'b1, ref_op(c1, a1, b1)}); accepted++; end
      step();
      if (hs0) v0 = 1'b0;
      if (hs1) v1 = 1'b0;
    end
    v0 = 1'b0; v1 = 1'b0;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          returned++;
          check("rnd_drain_id",     rsp_id,     e.id);
          check("rnd_drain_result", rsp_result, e.res);
        end
      end
      step();
    end
    check("rnd_outstanding", W'(exp_q.size()), 0);
    check("rnd_returned",    W'(returned),     W'(accepted));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
